// File: rtl/uart_rx_framer.sv
// Byte-stream framer behind a UART receiver: finds SYNC_BYTE, LEN, payload, CSUM,
// checks the XOR checksum, and replays a verified payload through a valid/ready port.
module uart_rx_framer #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_CSUM    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  state_t           state;
  state_t           state_n;
  logic [7:0]       len_q;
  logic [7:0]       csum_q;
  logic [7:0]       wr_ptr;
  logic [7:0]       rd_ptr;
  logic [CNT_W-1:0] idle_cnt;
  logic [7:0]       buf_mem [MAX_LEN];
  logic             frame_err_q;
  err_t             err_code_q;

  logic len_ok;
  logic csum_ok;
  logic last_wr;
  logic last_rd;
  logic timeout;
  logic in_frame;
  logic in_frame_n;
  logic err_set;
  err_t err_kind;

  assign len_ok     = (rx_data != 8'd0) && ({24'd0, rx_data} <= 32'(MAX_LEN));
  assign csum_ok    = (rx_data == csum_q);
  assign last_wr    = (wr_ptr == len_q - 8'd1);
  assign last_rd    = (rd_ptr == len_q - 8'd1);
  assign timeout    = (idle_cnt == IDLE_LAST);
  assign in_frame   = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  assign in_frame_n = (state_n == ST_LEN) || (state_n == ST_PAYLOAD) || (state_n == ST_CSUM);

  // NOTE: every register here is written with <= so all flops update from
  // the same pre-edge values; blocking assignments would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HUNT;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: each combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    err_set  = 1'b0;
    err_kind = ERR_NONE;
    unique case (state)
      ST_HUNT: begin
        if (rx_done && (rx_data == SYNC_BYTE)) state_n = ST_LEN;
      end
      ST_LEN: begin
        if (rx_done) begin
          if (len_ok) begin
            state_n = ST_PAYLOAD;
          end else begin
            state_n  = ST_HUNT;
            err_set  = 1'b1;
            err_kind = ERR_LEN;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_done && last_wr) state_n = ST_CSUM;
      end
      ST_CSUM: begin
        if (rx_done) begin
          if (csum_ok) begin
            state_n = ST_DRAIN;
          end else begin
            state_n  = ST_HUNT;
            err_set  = 1'b1;
            err_kind = ERR_CSUM;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready && last_rd) state_n = ST_HUNT;
      end
      default: state_n = ST_HUNT;
    endcase

    // A byte arriving on the final idle clock still counts as activity.
    if (in_frame && !rx_done && timeout) begin
      state_n  = ST_HUNT;
      err_set  = 1'b1;
      err_kind = ERR_TIMEOUT;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    overrun   = 1'b0;
    out_data  = 8'h00;
    if (state == ST_DRAIN) begin
      out_valid = 1'b1;
      out_last  = last_rd;
      overrun   = rx_done;
      out_data  = buf_mem[rd_ptr[PTR_W-1:0]];
    end
  end

  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= 8'd0;
      csum_q      <= 8'd0;
      wr_ptr      <= 8'd0;
      rd_ptr      <= 8'd0;
      idle_cnt    <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      frame_err_q <= err_set;
      if (err_set) err_code_q <= err_kind;

      if (in_frame_n && in_frame && !rx_done) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end else begin
        idle_cnt <= '0;
      end

      if ((state == ST_LEN) && rx_done && len_ok) begin
        len_q  <= rx_data;
        csum_q <= rx_data;
        wr_ptr <= 8'd0;
      end

      if ((state == ST_PAYLOAD) && rx_done) begin
        csum_q <= csum_q ^ rx_data;
        wr_ptr <= wr_ptr + 8'd1;
      end

      if ((state == ST_CSUM) && rx_done && csum_ok) begin
        rd_ptr <= 8'd0;
      end else if ((state == ST_DRAIN) && out_ready) begin
        rd_ptr <= rd_ptr + 8'd1;
      end
    end
  end

  // NOTE: the payload buffer has no reset; it is only read after being
  // written by the current frame, so clearing it would add logic for nothing.
  always_ff @(posedge clk) begin
    if ((state == ST_PAYLOAD) && rx_done) begin
      buf_mem[wr_ptr[PTR_W-1:0]] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: table of frames plus directed corner
// sequences, with expected payload bytes and error codes scoreboarded in queues.
module tb_uart_rx_framer;

  localparam logic [7:0] SYNC         = 8'hA5;
  localparam int         MAX_LEN      = 16;
  localparam int         TIMEOUT_CLKS = 25000;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  uart_rx_framer #(
    .SYNC_BYTE   (SYNC),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .frame_err(frame_err),
    .err_code (err_code),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    int                 n;
    logic [19:0][7:0]   bytes;
    int                 pn;
    logic [15:0][7:0]   pay;
    logic [1:0]         err;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  vec_t       vecs[$];
  exp_t       exp_q[$];
  logic [1:0] err_q[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
  endtask

  // Bytes and payload are listed left-to-right in stream order.
  task automatic add_vec(input string nm, input int n, input logic [19:0][7:0] b,
                         input int pn, input logic [15:0][7:0] p, input logic [1:0] e);
    vec_t v;
    v.name = nm;
    v.n    = n;
    v.pn   = pn;
    v.err  = e;
    for (int i = 0; i < 20; i++) v.bytes[i] = (i < n) ? b[n-1-i] : 8'h00;
    for (int i = 0; i < 16; i++) v.pay[i] = (i < pn) ? p[pn-1-i] : 8'h00;
    vecs.push_back(v);
  endtask

  // Called 1 time unit after a rising edge; returns likewise.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pay(input logic [7:0] b, input logic last);
    exp_t e;
    e.data = b;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wait_quiet(input string name);
    idle_cycles(MAX_LEN + 6);
    check({name, "_out_pending"}, exp_q.size(), 0);
    check({name, "_err_pending"}, err_q.size(), 0);
    exp_q.delete();
    err_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out", {24'd0, out_data});
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, mon_e.data});
          check("out_last", {31'd0, out_last}, {31'd0, mon_e.last});
        end
      end
      if (frame_err) begin
        check("err_with_valid", {31'd0, out_valid}, 32'd0);
        if (err_q.size() == 0) fail_now("unexpected_err", {30'd0, err_code});
        else check("err_code", {30'd0, err_code}, {30'd0, err_q.pop_front()});
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   cnt;

    rst       = 1'b1;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    out_ready = 1'b1;

    // XOR checksum of each frame is LEN ^ payload; 03^11^22^33 = 03.
    add_vec("basic3",    6, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}, 3, {8'h11, 8'h22, 8'h33}, 2'b00);
    add_vec("bad_csum",  5, {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}, 0, '0, 2'b10);
    add_vec("len_zero",  2, {8'hA5, 8'h00}, 0, '0, 2'b01);
    add_vec("len_17",    2, {8'hA5, 8'h11}, 0, '0, 2'b01);
    add_vec("single",    4, {8'hA5, 8'h01, 8'h7E, 8'h7F}, 1, {8'h7E}, 2'b00);
    add_vec("junk_lead", 7, {8'h3C, 8'h5A, 8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD}, 2, {8'hC3, 8'h3C}, 2'b00);
    add_vec("sync_pay",  4, {8'hA5, 8'h01, 8'hA5, 8'hA4}, 1, {8'hA5}, 2'b00);
    add_vec("len_ff",    2, {8'hA5, 8'hFF}, 0, '0, 2'b01);
    add_vec("csum_off",  4, {8'hA5, 8'h01, 8'h7E, 8'h7E}, 0, '0, 2'b10);
    // Maximum length: payload i*0x11 XORs to 00, so CSUM = LEN = 10.
    v.name = "max_len";
    v.n    = 19;
    v.pn   = 16;
    v.err  = 2'b00;
    v.bytes = '0;
    v.bytes[0] = SYNC;
    v.bytes[1] = 8'h10;
    for (int i = 0; i < 16; i++) begin
      v.bytes[2+i] = 8'(i * 17);
      v.pay[i]     = 8'(i * 17);
    end
    v.bytes[18] = 8'h10;
    vecs.push_back(v);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun",   {31'd0, overrun},   32'd0);
    check("rst_err_code",  {30'd0, err_code},  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].pn; i++) expect_pay(vecs[k].pay[i], i == vecs[k].pn - 1);
      if (vecs[k].err != 2'b00) err_q.push_back(vecs[k].err);
      for (int i = 0; i < vecs[k].n; i++) begin
        send_byte(vecs[k].bytes[i]);
        idle_cycles(int'($urandom_range(2, 0)));
      end
      wait_quiet(vecs[k].name);
    end

    // Timeout after A5,02,AA: pulse follows exactly TIMEOUT_CLKS idle clocks.
    err_q.push_back(2'b11);
    send_byte(SYNC);
    send_byte(8'h02);
    send_byte(8'hAA);
    cnt = 0;
    while (cnt < TIMEOUT_CLKS + 10) begin
      @(negedge clk);
      cnt++;
      if (frame_err) break;
    end
    check("timeout_clks", cnt, TIMEOUT_CLKS + 1);
    @(negedge clk);
    check("timeout_pulse_width", {31'd0, frame_err}, 32'd0);
    check("timeout_code_held",   {30'd0, err_code},  32'd3);
    @(posedge clk);
    #1;
    expect_pay(8'h7E, 1'b1);
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h7E);
    send_byte(8'h7F);
    wait_quiet("after_timeout");

    // Overrun during a stalled drain; the dropped SYNC must not start a frame.
    out_ready = 1'b0;
    expect_pay(8'h5A, 1'b0);
    expect_pay(8'hC6, 1'b1);
    send_byte(SYNC);
    send_byte(8'h02);
    send_byte(8'h5A);
    send_byte(8'hC6);
    send_byte(8'h9E);
    @(negedge clk);
    check("drain_valid_rise", {31'd0, out_valid}, 32'd1);
    check("drain_first_data", {24'd0, out_data},  32'h5A);
    rx_data = SYNC;
    rx_done = 1'b1;
    @(negedge clk);
    check("overrun_pulse",    {31'd0, overrun},  32'd1);
    check("overrun_data_hold", {24'd0, out_data}, 32'h5A);
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    @(negedge clk);
    check("overrun_clear",    {31'd0, overrun},   32'd0);
    check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
    check("stall_data_hold",  {24'd0, out_data},  32'h5A);
    check("stall_last_low",   {31'd0, out_last},  32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_quiet("overrun_drain");
    send_byte(8'h01);
    send_byte(8'h77);
    send_byte(8'h76);
    wait_quiet("no_capture_after_drain");

    // Reset in PAYLOAD abandons the frame silently and clears err_code.
    send_byte(SYNC);
    send_byte(8'h03);
    send_byte(8'h11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_frame_err",  {31'd0, frame_err}, 32'd0);
    check("rst_mid_frame_code", {30'd0, err_code},  32'd0);
    @(posedge clk);
    #1;
    expect_pay(8'h55, 1'b1);
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h54);
    wait_quiet("after_rst_payload");

    // Reset during a stalled drain drops the pending output.
    out_ready = 1'b0;
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h66);
    send_byte(8'h67);
    @(negedge clk);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_drain_valid", {31'd0, out_valid}, 32'd0);
    check("rst_drain_last",  {31'd0, out_last},  32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_quiet("after_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
